// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes and special register IDs.
// Used by the fetch, decode/writeback and execute blocks.
package y86_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned RIDW   = 4;
    localparam int unsigned NREG   = 15;

    localparam logic [RIDW-1:0] RNONE = 4'hF;
    localparam logic [RIDW-1:0] RSP   = 4'h4;

    typedef enum logic [3:0] {
        IHALT   = 4'h0,
        INOP    = 4'h1,
        IRRMOVQ = 4'h2,
        IIRMOVQ = 4'h3,
        IRMMOVQ = 4'h4,
        IMRMOVQ = 4'h5,
        IOPQ    = 4'h6,
        IJXX    = 4'h7,
        ICALL   = 4'h8,
        IRET    = 4'h9,
        IPUSHQ  = 4'hA,
        IPOPQ   = 4'hB
    } icode_e;

endpackage

// File: rtl/regfile.sv
// Architectural register file: two combinational read ports, a debug port and
// two synchronous write ports (E then M, so M wins on an address collision).
module regfile #(
    parameter int unsigned NREG  = 15,
    parameter logic [3:0]  RNONE = 4'hF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [3:0]  i_rd_addr_a,
    input  logic [3:0]  i_rd_addr_b,
    input  logic [3:0]  i_dbg_addr,
    input  logic [3:0]  i_wr_addr_e,
    input  logic [63:0] i_wr_data_e,
    input  logic [3:0]  i_wr_addr_m,
    input  logic [63:0] i_wr_data_m,
    output logic [63:0] o_rd_data_a,
    output logic [63:0] o_rd_data_b,
    output logic [63:0] o_dbg_data
);

    logic [63:0] r_regs [NREG];
    logic        w_we_e;
    logic        w_we_m;

    assign w_we_e = (i_wr_addr_e != RNONE) && (32'(i_wr_addr_e) < NREG);
    assign w_we_m = (i_wr_addr_m != RNONE) && (32'(i_wr_addr_m) < NREG);

    // Reset clears every entry and suppresses that cycle's writes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                r_regs[i] <= 64'h0;
            end
        end else begin
            if (w_we_e) r_regs[i_wr_addr_e] <= i_wr_data_e;
            if (w_we_m) r_regs[i_wr_addr_m] <= i_wr_data_m;
        end
    end

    // Reads see the pre-write array; same-cycle bypass is done by the W forward.
    always_comb begin
        o_rd_data_a = 64'h0;
        o_rd_data_b = 64'h0;
        o_dbg_data  = 64'h0;
        if (i_rd_addr_a != RNONE && 32'(i_rd_addr_a) < NREG) o_rd_data_a = r_regs[i_rd_addr_a];
        if (i_rd_addr_b != RNONE && 32'(i_rd_addr_b) < NREG) o_rd_data_b = r_regs[i_rd_addr_b];
        if (i_dbg_addr  != RNONE && 32'(i_dbg_addr)  < NREG) o_dbg_data  = r_regs[i_dbg_addr];
    end

endmodule

// File: rtl/decode_writeback.sv
// Y86-64 pipeline decode/writeback stage: register ID decode, operand
// forwarding from E/M/W, and the architectural register file.
module decode_writeback #(
    parameter int unsigned NREG  = y86_pkg::NREG,
    parameter logic [3:0]  RNONE = y86_pkg::RNONE,
    parameter logic [3:0]  RSP   = y86_pkg::RSP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  D_icode,
    input  logic [3:0]  D_rA,
    input  logic [3:0]  D_rB,
    input  logic [63:0] D_valP,
    input  logic [3:0]  e_dstE,
    input  logic [3:0]  M_dstE,
    input  logic [3:0]  M_dstM,
    input  logic [3:0]  W_dstE,
    input  logic [3:0]  W_dstM,
    input  logic [63:0] e_valE,
    input  logic [63:0] M_valE,
    input  logic [63:0] m_valM,
    input  logic [63:0] W_valE,
    input  logic [63:0] W_valM,
    input  logic [3:0]  dbg_addr,
    output logic [3:0]  d_srcA,
    output logic [3:0]  d_srcB,
    output logic [3:0]  d_dstE,
    output logic [3:0]  d_dstM,
    output logic [63:0] d_valA,
    output logic [63:0] d_valB,
    output logic [63:0] dbg_val
);

    logic [63:0] w_rf_a;
    logic [63:0] w_rf_b;

    regfile #(
        .NREG  (NREG),
        .RNONE (RNONE)
    ) u_regfile (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_rd_addr_a (d_srcA),
        .i_rd_addr_b (d_srcB),
        .i_dbg_addr  (dbg_addr),
        .i_wr_addr_e (W_dstE),
        .i_wr_data_e (W_valE),
        .i_wr_addr_m (W_dstM),
        .i_wr_data_m (W_valM),
        .o_rd_data_a (w_rf_a),
        .o_rd_data_b (w_rf_b),
        .o_dbg_data  (dbg_val)
    );

    // Register ID decode; cmov condition gating of dstE happens in execute.
    always_comb begin
        d_srcA = RNONE;
        d_srcB = RNONE;
        d_dstE = RNONE;
        d_dstM = RNONE;
        case (D_icode)
            y86_pkg::IRRMOVQ, y86_pkg::IRMMOVQ, y86_pkg::IOPQ, y86_pkg::IPUSHQ: d_srcA = D_rA;
            y86_pkg::IRET, y86_pkg::IPOPQ:                                     d_srcA = RSP;
            default: ;
        endcase
        case (D_icode)
            y86_pkg::IRMMOVQ, y86_pkg::IMRMOVQ, y86_pkg::IOPQ:                 d_srcB = D_rB;
            y86_pkg::ICALL, y86_pkg::IRET, y86_pkg::IPUSHQ, y86_pkg::IPOPQ:    d_srcB = RSP;
            default: ;
        endcase
        case (D_icode)
            y86_pkg::IRRMOVQ, y86_pkg::IIRMOVQ, y86_pkg::IOPQ:                 d_dstE = D_rB;
            y86_pkg::ICALL, y86_pkg::IRET, y86_pkg::IPUSHQ, y86_pkg::IPOPQ:    d_dstE = RSP;
            default: ;
        endcase
        case (D_icode)
            y86_pkg::IMRMOVQ, y86_pkg::IPOPQ:                                  d_dstM = D_rA;
            default: ;
        endcase
    end

    // Forwarding: youngest producer first; RNONE sources never match.
    always_comb begin
        d_valA = 64'h0;
        d_valB = 64'h0;
        if (D_icode == y86_pkg::IJXX || D_icode == y86_pkg::ICALL) d_valA = D_valP;
        else if (d_srcA == RNONE)  d_valA = 64'h0;
        else if (d_srcA == e_dstE) d_valA = e_valE;
        else if (d_srcA == M_dstM) d_valA = m_valM;
        else if (d_srcA == M_dstE) d_valA = M_valE;
        else if (d_srcA == W_dstM) d_valA = W_valM;
        else if (d_srcA == W_dstE) d_valA = W_valE;
        else                       d_valA = w_rf_a;

        if (d_srcB == RNONE)       d_valB = 64'h0;
        else if (d_srcB == e_dstE) d_valB = e_valE;
        else if (d_srcB == M_dstM) d_valB = m_valM;
        else if (d_srcB == M_dstE) d_valB = M_valE;
        else if (d_srcB == W_dstM) d_valB = W_valM;
        else if (d_srcB == W_dstE) d_valB = W_valE;
        else                       d_valB = w_rf_b;
    end

endmodule

// File: tb/tb_decode_writeback.sv
// Randomized self-checking bench for decode_writeback against a behavioural
// register-file/forwarding model, plus directed literal scenarios.
module tb_decode_writeback;

    localparam logic [3:0] NONE = 4'hF;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  D_icode, D_rA, D_rB;
    logic [63:0] D_valP;
    logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
    logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
    logic [3:0]  dbg_addr;
    logic [3:0]  d_srcA, d_srcB, d_dstE, d_dstM;
    logic [63:0] d_valA, d_valB, dbg_val;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;
    logic [63:0] mregs [15];

    decode_writeback dut (
        .clk(clk), .rst(rst),
        .D_icode(D_icode), .D_rA(D_rA), .D_rB(D_rB), .D_valP(D_valP),
        .e_dstE(e_dstE), .M_dstE(M_dstE), .M_dstM(M_dstM),
        .W_dstE(W_dstE), .W_dstM(W_dstM),
        .e_valE(e_valE), .M_valE(M_valE), .m_valM(m_valM),
        .W_valE(W_valE), .W_valM(W_valM),
        .dbg_addr(dbg_addr),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .d_dstE(d_dstE), .d_dstM(d_dstM),
        .d_valA(d_valA), .d_valB(d_valB), .dbg_val(dbg_val)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of the decode tables.
    function automatic logic [3:0] m_srcA(input logic [3:0] ic, input logic [3:0] ra);
        if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
        if (ic inside {4'h9, 4'hB}) return 4'h4;
        return NONE;
    endfunction

    function automatic logic [3:0] m_srcB(input logic [3:0] ic, input logic [3:0] rb);
        if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return NONE;
    endfunction

    function automatic logic [3:0] m_dstE(input logic [3:0] ic, input logic [3:0] rb);
        if (ic inside {4'h2, 4'h3, 4'h6}) return rb;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return NONE;
    endfunction

    function automatic logic [3:0] m_dstM(input logic [3:0] ic, input logic [3:0] ra);
        if (ic inside {4'h5, 4'hB}) return ra;
        return NONE;
    endfunction

    // Operand value: ordered list of forwarding sources, then the model array.
    function automatic logic [63:0] m_operand(input logic [3:0] src);
        logic [3:0]  ids  [5];
        logic [63:0] vals [5];
        ids[0] = e_dstE; vals[0] = e_valE;
        ids[1] = M_dstM; vals[1] = m_valM;
        ids[2] = M_dstE; vals[2] = M_valE;
        ids[3] = W_dstM; vals[3] = W_valM;
        ids[4] = W_dstE; vals[4] = W_valE;
        if (src == NONE) return 64'h0;
        for (int k = 0; k < 5; k++) begin
            if (ids[k] == src) return vals[k];
        end
        return mregs[src];
    endfunction

    // Model state update.
    always @(posedge clk) begin
        if (rst === 1'b1) begin
            for (int i = 0; i < 15; i++) mregs[i] = 64'h0;
        end else begin
            if (W_dstE != NONE) mregs[W_dstE] = W_valE;
            if (W_dstM != NONE) mregs[W_dstM] = W_valM;
        end
    end

    // Compare process: every output on every enabled cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [3:0]  sa, sb;
            logic [63:0] ea;
            sa = m_srcA(D_icode, D_rA);
            sb = m_srcB(D_icode, D_rB);
            ea = (D_icode == 4'h7 || D_icode == 4'h8) ? D_valP : m_operand(sa);
            chk("srcA", 64'(d_srcA), 64'(sa));
            chk("srcB", 64'(d_srcB), 64'(sb));
            chk("dstE", 64'(d_dstE), 64'(m_dstE(D_icode, D_rB)));
            chk("dstM", 64'(d_dstM), 64'(m_dstM(D_icode, D_rA)));
            chk("valA", d_valA, ea);
            chk("valB", d_valB, m_operand(sb));
            chk("dbg",  dbg_val, (dbg_addr == NONE) ? 64'h0 : mregs[dbg_addr]);
        end
    end

    task automatic idle_inputs();
        D_icode = 4'h1; D_rA = NONE; D_rB = NONE; D_valP = 64'h0;
        e_dstE = NONE; M_dstE = NONE; M_dstM = NONE; W_dstE = NONE; W_dstM = NONE;
        e_valE = 64'h0; M_valE = 64'h0; m_valM = 64'h0; W_valE = 64'h0; W_valM = 64'h0;
        dbg_addr = NONE;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] rnd_reg();
        return 4'($urandom_range(0, 15));
    endfunction

    initial begin
        for (int i = 0; i < 15; i++) mregs[i] = 64'h0;
        rst = 1'b1;
        idle_inputs();
        step();
        rst = 1'b0;
        chk_en = 1'b1;

        // Reset state of every register.
        for (int a = 0; a < 15; a++) begin
            dbg_addr = 4'(a);
            #2 chk("rst_dbg", dbg_val, 64'h0);
            step();
        end
        dbg_addr = NONE;
        #2 chk("dbg_none", dbg_val, 64'h0);

        // Write reg 3 then read it through both ports.
        W_dstE = 4'd3; W_valE = 64'h55;
        step();
        idle_inputs();
        D_icode = 4'h6; D_rA = 4'd3; D_rB = 4'd3;
        #2;
        chk("opq_valA", d_valA, 64'h55);
        chk("opq_valB", d_valB, 64'h55);
        chk("opq_dstE", 64'(d_dstE), 64'd3);
        step();

        // Forwarding priority e > M > W.
        idle_inputs();
        e_dstE = 4'd2; e_valE = 64'h11;
        M_dstE = 4'd2; M_valE = 64'h22;
        W_dstE = 4'd2; W_valE = 64'h33;
        D_icode = 4'h2; D_rA = 4'd2; D_rB = 4'd7;
        #2 chk("fwd_e", d_valA, 64'h11);
        e_dstE = NONE;
        #2 chk("fwd_M", d_valA, 64'h22);
        step();

        // Same-address writeback: M port wins.
        idle_inputs();
        W_dstE = 4'd4; W_valE = 64'h100;
        W_dstM = 4'd4; W_valM = 64'h200;
        step();
        idle_inputs();
        dbg_addr = 4'd4;
        #2 chk("wb_mwins", dbg_val, 64'h200);
        step();

        // call: valA is valP, srcB/dstE are RSP, valB forwarded from e.
        idle_inputs();
        D_icode = 4'h8; D_valP = 64'h40;
        e_dstE = 4'd4; e_valE = 64'hABC;
        #2;
        chk("call_valA", d_valA, 64'h40);
        chk("call_srcB", 64'(d_srcB), 64'd4);
        chk("call_dstE", 64'(d_dstE), 64'd4);
        chk("call_valB", d_valB, 64'hABC);
        step();

        // Mid-program reset overrides a pending write.
        idle_inputs();
        W_dstE = 4'd5; W_valE = 64'h77;
        step();
        idle_inputs();
        dbg_addr = 4'd5;
        #2 chk("pre_rst5", dbg_val, 64'h77);
        rst = 1'b1;
        W_dstE = 4'd6; W_valE = 64'h9;
        step();
        rst = 1'b0;
        idle_inputs();
        dbg_addr = 4'd5;
        #2 chk("post_rst5", dbg_val, 64'h0);
        dbg_addr = 4'd6;
        #2 chk("post_rst6", dbg_val, 64'h0);
        step();

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            rst     = ($urandom_range(0, 59) == 0);
            D_icode = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 11));
            D_rA    = rnd_reg();
            D_rB    = rnd_reg();
            D_valP  = {$urandom, $urandom};
            e_dstE  = rnd_reg(); M_dstE = rnd_reg(); M_dstM = rnd_reg();
            W_dstE  = rnd_reg(); W_dstM = rnd_reg();
            if ($urandom_range(0, 1) == 1) begin
                e_dstE = NONE; M_dstE = NONE; M_dstM = NONE;
            end
            e_valE = {$urandom, $urandom}; M_valE = {$urandom, $urandom};
            m_valM = {$urandom, $urandom}; W_valE = {$urandom, $urandom};
            W_valM = {$urandom, $urandom};
            dbg_addr = rnd_reg();
            step();
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
